// File: rtl/mod_add.sv
// mod_add: two-stage modular adder, c_o = (a_i + b_i) mod q_i, fully reduced for any operands
module mod_add #(
  parameter int A_W = 24,
  parameter int Q_W = 23
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           valid_i,
  input  logic [A_W-1:0] a_i,
  input  logic [A_W-1:0] b_i,
  input  logic [Q_W-1:0] q_i,
  output logic           valid_o,
  output logic [Q_W-1:0] c_o
);
  localparam int R_W = 2 * A_W;
  logic           v_q;
  logic [A_W:0]   s_q;
  logic [Q_W-1:0] m_q;
  logic [Q_W-1:0] red;
  // Restoring remainder over the full sum; a zero modulus is defined to give zero
  function automatic logic [Q_W-1:0] reduce(input logic [A_W:0] s, input logic [Q_W-1:0] q);
    logic [R_W-1:0] r;
    logic [R_W-1:0] m;
    r = R_W'(s);
    for (int k = A_W; k >= 0; k--) begin
      m = R_W'(q) << k;
      if (r >= m) r = r - m;
    end
    return (q == '0) ? '0 : r[Q_W-1:0];
  endfunction
  // Input stage: capture the carry-preserving sum and the modulus
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= 1'b0;
      s_q <= '0;
      m_q <= '0;
    end else begin
      v_q <= valid_i;
      if (valid_i) begin
        s_q <= {1'b0, a_i} + {1'b0, b_i};
        m_q <= q_i;
      end
    end
  end
  // Reduction between the two register stages
  always_comb red = reduce(s_q, m_q);
  // Output stage: result only updates on a valid op, otherwise holds
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      c_o     <= '0;
    end else begin
      valid_o <= v_q;
      if (v_q) c_o <= red;
    end
  end
endmodule

// File: tb/tb_mod_add.sv
// tb_mod_add: scoreboard bench for mod_add, directed vectors plus a streamed run
module tb_mod_add;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic [23:0] a_i = '0;
  logic [23:0] b_i = '0;
  logic [22:0] q_i = '0;
  logic        valid_o;
  logic [22:0] c_o;
  typedef struct {
    logic [22:0] c;
    int          cyc;
    string       name;
  } exp_t;
  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [22:0] last_c = '0;
  mod_add dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .a_i(a_i), .b_i(b_i),
    .q_i(q_i), .valid_o(valid_o), .c_o(c_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Monitor: pop and compare whenever a result is presented, else check hold
  always @(negedge clk) begin
    if (rst_ni) begin
      if (valid_o === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: c_o=%0d with no pending op at cycle %0d", c_o, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (c_o !== e.c || cyc != e.cyc) begin
            errors++;
            $display("FAIL %s: got c_o=%0d at cycle %0d, want %0d at cycle %0d", e.name, c_o, cyc, e.c, e.cyc);
          end
          last_c = e.c;
        end
      end else begin
        checks++;
        if (valid_o !== 1'b0 || c_o !== last_c) begin
          errors++;
          $display("FAIL idle_hold: got valid_o=%b c_o=%0d, want valid_o=0 c_o=%0d", valid_o, c_o, last_c);
        end
      end
    end
  end
  task automatic issue(input logic [23:0] a, input logic [23:0] b, input logic [22:0] q,
                       input logic [22:0] c, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    valid_i = 1'b1;
    a_i = a;
    b_i = b;
    q_i = q;
    e.c = c;
    e.cyc = cyc + 2;
    e.name = name;
    sb.push_back(e);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      a_i = 24'h5a5a5a;
      b_i = 24'ha5a5a5;
      q_i = 23'd7;
    end
  endtask
  task automatic chk(input logic [22:0] got_c, input logic got_v, input string name);
    checks++;
    if (got_v !== 1'b0 || got_c !== 23'd0) begin
      errors++;
      $display("FAIL %s: got valid_o=%b c_o=%0d, want valid_o=0 c_o=0", name, got_v, got_c);
    end
  endtask
  initial begin
    #1;
    chk(c_o, valid_o, "reset_state");
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    issue(24'd20, 24'd3, 23'd40, 23'd23, "basic");
    idle(3);
    issue(24'd20, 24'd21, 23'd40, 23'd1, "single_wrap");
    issue(24'd0, 24'd0, 23'd40, 23'd0, "zero_ops");
    issue(24'd16777215, 24'd16777215, 23'd40, 23'd30, "max_sum_q40");
    issue(24'd123, 24'd456, 23'd1, 23'd0, "q_one");
    issue(24'd16777215, 24'd16777215, 23'd1, 23'd0, "q_one_max");
    issue(24'd5, 24'd7, 23'd0, 23'd0, "q_zero");
    issue(24'd60, 24'd70, 23'd100, 23'd30, "fast_path");
    issue(24'd8388606, 24'd8388606, 23'd8388607, 23'd8388605, "fast_path_max");
    issue(24'd16777215, 24'd16777215, 23'd8388607, 23'd2, "max_sum_qmax");
    issue(24'd16777215, 24'd0, 23'd8388607, 23'd1, "a_only_qmax");
    idle(4);
    for (int i = 0; i < 40; i++) begin
      logic [23:0] a;
      logic [23:0] b;
      longint      r;
      a = 24'($urandom);
      b = 24'($urandom);
      r = (longint'(a) + longint'(b)) % 64'd8388607;
      issue(a, b, 23'd8388607, 23'(r), "stream");
    end
    idle(4);
    issue(24'd20, 24'd3, 23'd40, 23'd23, "pre_reset_a");
    issue(24'd20, 24'd21, 23'd40, 23'd1, "pre_reset_b");
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    valid_i = 1'b0;
    sb.delete();
    last_c = '0;
    #1;
    chk(c_o, valid_o, "async_reset_clear");
    repeat (3) @(posedge clk);
    #1;
    chk(c_o, valid_o, "reset_hold");
    rst_ni = 1'b1;
    idle(4);
    issue(24'd39, 24'd39, 23'd40, 23'd38, "post_reset");
    idle(1);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, want 0", sb.size());
    end
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
